count_seq_checker: RTL and testbench

- Receive-side counterpart of the free-running 8-bit counter block: consumes a sampled count stream and verifies that each valid sample equals the previous sample plus one, modulo 2^WIDTH.
- Sits downstream of a counter under test in architecture test harnesses. Reports lock status, per-mismatch pulses, a sticky error flag, a saturating error count and the values of the first mismatch.
- Synthesizable, so the check itself can run on-chip.

---
 rtl/count_chk_pkg.sv | 24 ++
 rtl/sat_counter.sv | 34 +++
 rtl/count_seq_checker.sv | 143 ++++++++++++++
 tb/tb_count_seq_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count sequence checker.
// Holds the FSM state encoding and parameter bounds.
package count_chk_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } chk_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERRW  = 16;
  localparam int RUNW      = 4;
  localparam int LOCK_MIN  = 2;
  localparam int LOCK_MAX  = 15;

  // Keep the lock threshold inside what the run counter can reach.
  function automatic int lock_clamp(input int n);
    if (n < LOCK_MIN) return LOCK_MIN;
    if (n > LOCK_MAX) return LOCK_MAX;
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks a sampled count stream for +1 steps.
// Reports lock, mismatch pulses, sticky error and first-mismatch capture.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = DEF_ERRW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] cap_exp,
  output logic [WIDTH-1:0] cap_got
);

  localparam logic [RUNW-1:0] LOCK_RUN =
    RUNW'(lock_clamp(LOCK_CNT));
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [RUNW-1:0]  RUN1 = RUNW'(1);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
  logic [WIDTH-1:0] cap_got_q, cap_got_d;
  logic             err_inc;
  logic             hit;

  assign hit = (data == exp_q);

  // Next-state and output decode; clear beats any sample.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    cap_exp_d = cap_exp_q;
    cap_got_d = cap_got_q;
    err_inc   = 1'b0;
    if (clear) begin
      state_d   = HUNT;
      exp_d     = '0;
      run_d     = '0;
      locked_d  = 1'b0;
      sticky_d  = 1'b0;
      cap_exp_d = '0;
      cap_got_d = '0;
    end else if (valid) begin
      unique case (state_q)
        HUNT: begin
          exp_d   = data + ONE;
          run_d   = RUN1;
          state_d = SYNC;
        end
        SYNC: begin
          if (hit) begin
            exp_d = exp_q + ONE;
            run_d = run_q + RUN1;
            if ((run_q + RUN1) == LOCK_RUN) begin
              state_d  = TRACK;
              locked_d = 1'b1;
            end
          end else begin
            exp_d = data + ONE;
            run_d = RUN1;
          end
        end
        TRACK: begin
          if (hit) begin
            exp_d = exp_q + ONE;
          end else begin
            err_d    = 1'b1;
            err_inc  = 1'b1;
            locked_d = 1'b0;
            exp_d    = data + ONE;
            run_d    = RUN1;
            state_d  = SYNC;
            if (!sticky_q) begin
              sticky_d  = 1'b1;
              cap_exp_d = exp_q;
              cap_got_d = data;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Checker state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      run_q     <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      cap_exp_q <= '0;
      cap_got_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      cap_exp_q <= cap_exp_d;
      cap_got_q <= cap_got_d;
    end
  end

  sat_counter #(
    .W(ERRW)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(reset_n),
    .clr  (clear),
    .inc  (err_inc),
    .count(err_count)
  );

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign cap_exp    = cap_exp_q;
  assign cap_got    = cap_got_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker.
// Second instance uses a 2-bit error counter for saturation.
module tb_count_seq_checker;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        valid;
  logic [7:0]  data;

  logic        locked, err, err_sticky;
  logic [15:0] err_count;
  logic [7:0]  cap_exp, cap_got;

  logic        locked2, err2, err_sticky2;
  logic [1:0]  err_count2;
  logic [7:0]  cap_exp2, cap_got2;

  int n_asserts = 0;
  int n_fails   = 0;

  count_seq_checker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .valid     (valid),
    .data      (data),
    .locked    (locked),
    .err       (err),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .cap_exp   (cap_exp),
    .cap_got   (cap_got)
  );

  count_seq_checker #(
    .ERRW(2)
  ) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .valid     (valid),
    .data      (data),
    .locked    (locked2),
    .err       (err2),
    .err_sticky(err_sticky2),
    .err_count (err_count2),
    .cap_exp   (cap_exp2),
    .cap_got   (cap_got2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_sticky"}, 32'(err_sticky), 0);
    chk({tag, "_count"}, 32'(err_count), 0);
    chk({tag, "_cap_exp"}, 32'(cap_exp), 0);
    chk({tag, "_cap_got"}, 32'(cap_got), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 8'd0);
    clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pre_v [7];
    logic       pre_l [7];
    logic [7:0] s;
    pre_v = '{8'd5, 8'd9, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    pre_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n = 1'b0;
    clear   = 1'b0;
    valid   = 1'b0;
    data    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i <= 300; i++) begin
      step(1'b1, 8'(i));
      chk("wrap_locked", 32'(locked), (i >= 3) ? 1 : 0);
      chk("wrap_err", 32'(err), 0);
    end
    chk("wrap_count", 32'(err_count), 0);

    do_clear();
    chk_zero("clr1");
    for (int i = 6; i <= 12; i++) begin
      step(1'b1, 8'(i));
      chk("glitch_pre_locked", 32'(locked), (i >= 9) ? 1 : 0);
      chk("glitch_pre_err", 32'(err), 0);
    end
    step(1'b1, 8'd40);
    chk("glitch_err", 32'(err), 1);
    chk("glitch_count", 32'(err_count), 1);
    chk("glitch_cap_exp", 32'(cap_exp), 13);
    chk("glitch_cap_got", 32'(cap_got), 40);
    chk("glitch_sticky", 32'(err_sticky), 1);
    chk("glitch_locked", 32'(locked), 0);
    for (int i = 41; i <= 44; i++) begin
      step(1'b1, 8'(i));
      chk("glitch_post_err", 32'(err), 0);
      chk("glitch_post_locked", 32'(locked), (i >= 43) ? 1 : 0);
    end
    chk("glitch_post_count", 32'(err_count), 1);
    chk("glitch_post_sticky", 32'(err_sticky), 1);

    do_clear();
    for (int i = 97; i <= 101; i++) begin
      step(1'b1, 8'(i));
    end
    chk("gap_locked_in", 32'(locked), 1);
    repeat (3) begin
      step(1'b0, 8'd7);
      chk("gap_idle_locked", 32'(locked), 1);
      chk("gap_idle_err", 32'(err), 0);
    end
    step(1'b1, 8'd102);
    chk("gap_102_err", 32'(err), 0);
    chk("gap_102_locked", 32'(locked), 1);
    step(1'b1, 8'd103);
    chk("gap_103_err", 32'(err), 0);
    chk("gap_count", 32'(err_count), 0);

    do_clear();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, pre_v[i]);
      chk("pre_err", 32'(err), 0);
      chk("pre_locked", 32'(locked), 32'(pre_l[i]));
    end
    chk("pre_count", 32'(err_count), 0);

    do_clear();
    for (int i = 0; i <= 3; i++) step(1'b1, 8'(i));
    step(1'b1, 8'd20);
    chk("mid_err1", 32'(err), 1);
    for (int i = 21; i <= 23; i++) step(1'b1, 8'(i));
    step(1'b1, 8'd60);
    chk("mid_err2", 32'(err), 1);
    for (int i = 61; i <= 63; i++) step(1'b1, 8'(i));
    chk("mid_count2", 32'(err_count), 2);
    chk("mid_locked", 32'(locked), 1);
    chk("mid_cap_exp", 32'(cap_exp), 4);
    chk("mid_cap_got", 32'(cap_got), 20);
    clear = 1'b1;
    step(1'b1, 8'd50);
    clear = 1'b0;
    chk_zero("clr_valid");
    for (int i = 51; i <= 54; i++) begin
      step(1'b1, 8'(i));
      chk("clr_relock", 32'(locked), (i == 54) ? 1 : 0);
      chk("clr_relock_err", 32'(err), 0);
    end
    step(1'b1, 8'd55);
    step(1'b1, 8'd90);
    chk("ar_err", 32'(err), 1);
    chk("ar_count", 32'(err_count), 1);
    chk("ar_cap_exp", 32'(cap_exp), 56);
    chk("ar_cap_got", 32'(cap_got), 90);
    for (int i = 91; i <= 93; i++) step(1'b1, 8'(i));
    chk("ar_locked_pre", 32'(locked), 1);
    chk("ar_sticky_pre", 32'(err_sticky), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      step(1'b1, 8'(i));
      chk("ar_relock", 32'(locked), (i == 3) ? 1 : 0);
    end

    reset_n = 1'b0;
    step(1'b0, 8'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j <= 3; j++) begin
        s = 8'(k * 10 + j);
        step(1'b1, s);
        chk("sat_err_idle", 32'(err2), 0);
        chk("sat_locked", 32'(locked2), (j == 3) ? 1 : 0);
      end
      step(1'b1, 8'(k * 10 + 100));
      chk("sat_err", 32'(err2), 1);
      chk("sat_count", 32'(err_count2), (k >= 2) ? 3 : k + 1);
      chk("sat_sticky", 32'(err_sticky2), 1);
      chk("sat_cap_exp", 32'(cap_exp2), 4);
      chk("sat_cap_got", 32'(cap_got2), 100);
    end
    step(1'b1, 8'd0);
    chk("sat_err_after", 32'(err2), 0);
    chk("sat_count_final", 32'(err_count2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
